// File: rtl/instruction_fetch_32.sv
// Instruction fetch unit for mips_cpu.
// Owns the program counter and fetches one word at a time from an instruction
// memory whose response latency varies. Each word is offered to the CPU under a
// valid/accept handshake, and the next PC is chosen from the redirect inputs
// present on the accept cycle. Both error flags are sticky. The unit parks in
// HALT after any error until reset.
module instruction_fetch_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_addr,
  output logic        imem_read_enabled,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        imem_err,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        err_misaligned,
  output logic        err_fetch
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic        mis_q;
  logic        mis_d;
  logic        ferr_q;
  logic        ferr_d;

  logic [31:0] next_pc;
  logic        next_misaligned;

  // The branch offset counts words. Sign-extend it, then scale it to bytes
  // before adding. The add wraps modulo 2^32.
  function automatic logic [31:0] branch_addr(input logic [31:0]        base,
                                              input logic signed [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return base + $unsigned(disp);
  endfunction

  // A j/jal target keeps the 256 MB region of the delay-slot address.
  function automatic logic [31:0] jump_addr(input logic [3:0]  region,
                                            input logic [25:0] tgt);
    return {region, tgt, 2'b00};
  endfunction

  // A register target must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign pc_plus4          = pc_q + 32'd4;
  assign pc                = pc_q;
  assign imem_addr         = pc_q;
  assign instruction       = instr_q;
  assign err_misaligned    = mis_q;
  assign err_fetch         = ferr_q;
  assign imem_read_enabled = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign instr_valid       = (state_q == ST_HOLD);

  // Select the next PC from the redirect inputs, highest priority first.
  // The result is used only on the accept cycle.
  always_comb begin
    next_pc         = pc_plus4;
    next_misaligned = 1'b0;
    if (jump_reg) begin
      if (is_misaligned(jump_reg_addr)) begin
        next_misaligned = 1'b1;
        next_pc         = pc_q;
      end else begin
        next_pc = jump_reg_addr;
      end
    end else if (jump) begin
      next_pc = jump_addr(pc_plus4[31:28], jump_target);
    end else if (branch_taken) begin
      next_pc = branch_addr(pc_plus4, branch_offset);
    end
  end

  // Next-state and datapath-load logic for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        // A request in flight always completes, even if enable has dropped.
        if (imem_ready) begin
          if (imem_err) begin
            ferr_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            instr_d = imem_data;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (instr_accept) begin
          if (next_misaligned) begin
            mis_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = enable ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State, PC, fetched word and sticky error flags.
  // All of them clear asynchronously on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_32.sv
// Testbench for instruction_fetch_32.
// The memory responder has a programmable latency, returns an address-derived
// word and can inject errors. A transaction-level reference model checks every
// cycle, and directed steps pin the model with literal values.
module tb_instruction_fetch_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_read_enabled;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        imem_err;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_accept = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0000;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        jump_reg = 1'b0;
  logic [31:0] jump_reg_addr = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        err_misaligned;
  logic        err_fetch;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  logic        err_inject = 1'b0;

  // Reference model state: the address of the word that must be fetched or
  // held next, plus the expected error and halt status.
  logic [31:0] exp_pc = 32'h0;
  logic        m_mis = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_halt = 1'b0;

  instruction_fetch_32 #(.RESET_PC(32'h0000_0000)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .imem_addr        (imem_addr),
    .imem_read_enabled(imem_read_enabled),
    .imem_data        (imem_data),
    .imem_ready       (imem_ready),
    .imem_err         (imem_err),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .instr_accept     (instr_accept),
    .branch_taken     (branch_taken),
    .branch_offset    (branch_offset),
    .jump             (jump),
    .jump_target      (jump_target),
    .jump_reg         (jump_reg),
    .jump_reg_addr    (jump_reg_addr),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .err_misaligned   (err_misaligned),
    .err_fetch        (err_fetch)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Returns {halt_on_misaligned, next_pc} given the address of the accepted word.
  function automatic logic [32:0] ref_next(input logic [31:0] p, input logic jr,
                                           input logic [31:0] jra, input logic j,
                                           input logic [25:0] jt, input logic br,
                                           input logic [15:0] off);
    logic [31:0] seq;
    logic [31:0] disp;
    seq  = p + 32'd4;
    disp = 32'($signed(off)) * 4;
    if (jr) return (jra % 4 != 0) ? {1'b1, p} : {1'b0, jra};
    if (j)  return {1'b0, seq[31:28], jt, 2'b00};
    if (br) return {1'b0, seq + disp};
    return {1'b0, seq};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: answers after 'lat' cycles of a held request.
  always_comb begin
    imem_ready = imem_read_enabled && (wait_cnt >= lat);
    imem_err   = imem_ready && err_inject;
    imem_data  = mem_word(imem_addr);
  end

  // Count the cycles that the current request has been waiting.
  always @(posedge clock) begin
    if (imem_read_enabled && !imem_ready) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  // Advance the reference model on each handshake or memory-error event.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_pc <= 32'h0;
      m_mis  <= 1'b0;
      m_ferr <= 1'b0;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (imem_read_enabled && imem_ready && imem_err) begin
        m_ferr <= 1'b1;
        m_halt <= 1'b1;
      end else if (instr_valid && instr_accept) begin
        logic [32:0] r;
        r = ref_next(exp_pc, jump_reg, jump_reg_addr, jump, jump_target,
                     branch_taken, branch_offset);
        exp_pc <= r[31:0];
        if (r[32]) begin
          m_mis  <= 1'b1;
          m_halt <= 1'b1;
        end
      end
    end
  end

  // Compare the DUT outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("model_err_misaligned", err_misaligned, m_mis);
      check("model_err_fetch", err_fetch, m_ferr);
      if (m_halt) begin
        check("model_halt_req", imem_read_enabled, 1'b0);
        check("model_halt_valid", instr_valid, 1'b0);
      end
      if (imem_read_enabled) check("model_fetch_addr", imem_addr, exp_pc);
      if (instr_valid) begin
        check("model_pc", pc, exp_pc);
        check("model_pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("model_instruction", instruction, mem_word(exp_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_hold(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, instr_valid, 1'b1);
  endtask

  task automatic accept_with(input logic br, input logic [15:0] off, input logic j,
                             input logic [25:0] jt, input logic jr, input logic [31:0] jra);
    branch_taken  = br;
    branch_offset = off;
    jump          = j;
    jump_target   = jt;
    jump_reg      = jr;
    jump_reg_addr = jra;
    instr_accept  = 1'b1;
    tick();
    instr_accept  = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0;
    jump          = 1'b0;
    jump_target   = 26'h0;
    jump_reg      = 1'b0;
    jump_reg_addr = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values.
    tick();
    tick();
    check("rst_instruction", instruction, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_read", imem_read_enabled, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_err_mis", err_misaligned, 1'b0);
    check("rst_err_fetch", err_fetch, 1'b0);

    // Zero-latency memory with accept tied high gives one word every two cycles.
    reset = 1'b0;
    enable = 1'b1;
    instr_accept = 1'b1;
    tick(); check("c1_read", imem_read_enabled, 1'b1); check("c1_addr", imem_addr, 32'h0);
            check("c1_valid", instr_valid, 1'b0);
    tick(); check("c2_valid", instr_valid, 1'b1); check("c2_pc", pc, 32'h0);
    tick(); check("c3_addr", imem_addr, 32'h4); check("c3_valid", instr_valid, 1'b0);
    tick(); check("c4_valid", instr_valid, 1'b1);
    tick(); check("c5_addr", imem_addr, 32'h8); check("c5_valid", instr_valid, 1'b0);
    tick(); check("c6_valid", instr_valid, 1'b1); check("c6_pc", pc, 32'h8);
            check("c6_pc_plus4", pc_plus4, 32'hC);
    instr_accept = 1'b0;

    // Branches taken backward and forward from pc=0x8.
    accept_with(1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    check("br_back_read", imem_read_enabled, 1'b1);
    check("br_back_addr", imem_addr, 32'h4);
    wait_hold("br_back_hold");
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    wait_hold("seq_hold8");
    accept_with(1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
    check("br_fwd_addr", imem_addr, 32'h18);
    wait_hold("br_fwd_hold");

    // When jump and branch_taken are both asserted, the jump wins.
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0000);
    check("jr_hi_addr", imem_addr, 32'h1000_0000);
    wait_hold("jr_hi_hold");
    accept_with(1'b1, 16'h0005, 1'b1, 26'h0000010, 1'b0, 32'h0);
    check("jump_addr", imem_addr, 32'h1000_0040);
    wait_hold("jump_hold");

    // Aligned register jump.
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0100);
    check("jr_addr", imem_addr, 32'h100);
    wait_hold("jr_hold");

    // With three cycles of memory latency, the request stays stable for four cycles.
    lat = 3;
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("lat_c0_addr", imem_addr, 32'h104);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_read", imem_read_enabled, 1'b1);
      check("lat_addr", imem_addr, 32'h104);
      check("lat_valid", instr_valid, 1'b0);
    end
    tick();
    check("lat_deliver_valid", instr_valid, 1'b1);
    check("lat_deliver_instr", instruction, mem_word(32'h104));

    // Hold accept low for five cycles while the redirect inputs toggle.
    // Without an accept, the redirects must have no effect.
    for (int i = 0; i < 5; i++) begin
      branch_taken  = i[0];
      jump_reg      = ~i[0];
      jump_reg_addr = 32'h0000_0003;
      tick();
      check("stall_valid", instr_valid, 1'b1);
      check("stall_pc", pc, 32'h104);
      check("stall_instr", instruction, mem_word(32'h104));
    end
    branch_taken = 1'b0;
    jump_reg = 1'b0;
    jump_reg_addr = 32'h0;
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    wait_hold("stall_next_hold");

    // Drop enable while the request is outstanding: the word is still delivered,
    // and the unit goes idle only after that word is accepted.
    lat = 2;
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    enable = 1'b0;
    check("en_req_addr", imem_addr, 32'h10C);
    wait_hold("en_deliver");
    check("en_deliver_pc", pc, 32'h10C);
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("idle_read", imem_read_enabled, 1'b0);
    check("idle_valid", instr_valid, 1'b0);
    check("idle_pc", pc, 32'h110);
    tick();
    tick();
    check("idle_read2", imem_read_enabled, 1'b0);
    enable = 1'b1;
    lat = 0;
    tick();
    check("resume_addr", imem_addr, 32'h110);
    wait_hold("resume_hold");

    // A misaligned register target halts the unit and leaves pc unchanged.
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0102);
    check("mis_flag", err_misaligned, 1'b1);
    check("mis_read", imem_read_enabled, 1'b0);
    check("mis_valid", instr_valid, 1'b0);
    check("mis_pc", pc, 32'h110);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_halt_read", imem_read_enabled, 1'b0);
    end

    // Assert reset partway through a WAIT cycle; the outputs must clear at once.
    reset = 1'b1;
    tick();
    check("rst2_mis", err_misaligned, 1'b0);
    reset = 1'b0;
    tick();
    wait_hold("rst2_hold0");
    lat = 5;
    accept_with(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    tick();
    check("wait_read", imem_read_enabled, 1'b1);
    check("wait_addr", imem_addr, 32'h4);
    #2 reset = 1'b1;
    #1;
    check("async_read", imem_read_enabled, 1'b0);
    check("async_addr", imem_addr, 32'h0);
    check("async_pc", pc, 32'h0);
    check("async_valid", instr_valid, 1'b0);
    check("async_instr", instruction, 32'h0);
    tick();

    // A memory error halts the unit and sets err_fetch.
    lat = 1;
    err_inject = 1'b1;
    reset = 1'b0;
    tick();
    check("ferr_req_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("ferr_flag", err_fetch, 1'b1);
    check("ferr_read", imem_read_enabled, 1'b0);
    check("ferr_valid", instr_valid, 1'b0);
    check("ferr_instr", instruction, 32'h0);
    tick();
    tick();
    check("ferr_halt_read", imem_read_enabled, 1'b0);
    err_inject = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
